snoop_bus_arbiter: RTL and testbench
====================================

// Module: snoop_bus_arbiter
// PURPOSE
//  Shares the single snooping MESI bus among NUM_CACHES cache controllers. Arbitration is round-robin.
//  Grants one transaction at a time and broadcasts op/addr/source to every snooper.
//  Runs a fixed snoop window, ORs the share line from all non-source caches, and returns done + shared to the requester.
//  Sits between each cache's MESI FSM bus-action outputs and the snooper observe inputs (gets_obs/getx_obs/inv_obs).
// PARAMETERS
//  NUM_CACHES    4   number of requesting caches (2..8)
//  ADDR_W        32  line address width
//  SNOOP_CYCLES  2   cycles in snoop window (>=1)
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    reset, synchronous, active-high
//  req            in   NUM_CACHES           per-cache request, held high until done[i]
//  req_op         in   NUM_CACHES x BusOp   requested op (BUS_GETS/GETX/INV/PUTX), stable while req
//  req_addr       in   NUM_CACHES x ADDR_W  requested line address, stable while req
//  snoop_share    in   NUM_CACHES           cache i holds line valid (pulls share)
//  gnt            out  NUM_CACHES           one-hot grant, high BCAST..DONE
//  bus_valid      out  1                    broadcast strobe, one cycle
//  bus_op         out  BusOp                op on bus (BUS_NONE when idle)
//  bus_addr       out  ADDR_W               address on bus
//  bus_src        out  $clog2(NUM_CACHES)   index of owning cache
//  done           out  NUM_CACHES           one-cycle completion pulse to the owner
//  shared         out  1                    valid with done: any other cache asserted snoop_share
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, rr_ptr=0.
//   - gnt, done, bus_valid and shared are 0.
//   - bus_op=BUS_NONE, bus_addr=0, bus_src=0.
//  FSM IDLE -> BCAST -> SNOOP -> DONE -> IDLE.
//  IDLE:
//   - If any req, the winner is the first set req at or after rr_ptr (wrapping modulo NUM_CACHES).
//   - Latch winner index, op and addr; go to BCAST. No req: stay in IDLE.
//  BCAST:
//   - bus_valid=1 for exactly one cycle.
//   - bus_op, bus_addr and bus_src are driven from the latched values and held until DONE.
//   - Clear share accumulator; go to SNOOP.
//  SNOOP:
//   - Stay SNOOP_CYCLES cycles.
//   - Each cycle, acc |= |(snoop_share & ~onehot(src)); the source's own share is ignored.
//  DONE:
//   - done[src]=1 and shared=acc for one cycle.
//   - rr_ptr=(src+1) mod NUM_CACHES; go to IDLE.
//   - For BUS_PUTX, shared is forced 0.
//  Latency: req seen in IDLE at cycle T -> bus_valid at T+1 -> done at T+2+SNOOP_CYCLES.
//  Back-to-back: the next arbitration happens in the IDLE cycle after DONE (one idle bubble, fixed).
//  Owner must drop req the cycle after done; a req still high then is treated as a new request.
//  req deasserted mid-transaction: ignored; the transaction completes and done still pulses.
//  req/op changes by non-owners while busy: no effect until next IDLE.
//  Reset mid-transaction: immediate return to IDLE, no done pulse, rr_ptr=0.
//  Only one cache ever sees gnt/done; gnt is 0 in IDLE.
// CONFIGURATION
//  ARB_PUTX_PRIORITY_EN defined:
//   - In IDLE, any req with req_op==BUS_PUTX wins over non-PUTX.
//   - Round-robin applies within the PUTX class first, then among the rest.
//  Not defined: pure round-robin over all req.
// STRUCTURE
//  cacheLinePackage: add typedef enum logic [2:0] BusOp {BUS_NONE, BUS_GETS, BUS_GETX, BUS_INV, BUS_PUTX}.
//  cacheLinePackage: add typedef enum ArbState {ARB_IDLE, ARB_BCAST, ARB_SNOOP, ARB_DONE}.
//  Sub-module rr_priority_picker (req vector + ptr -> one-hot winner + index, combinational).
//  The ARB_PUTX_PRIORITY_EN build instantiates rr_priority_picker twice.
// TESTING (NUM_CACHES=4, SNOOP_CYCLES=2)
//  1. Single req[1]=GETS addr 0x40, snoop_share[3]=1 in SNOOP -> bus_valid T+1, bus_op=GETS, bus_src=1, done[1] at T+4, shared=1.
//  2. req=4'b1111 held -> grant order 0,1,2,3,0; done at T+4, T+9, T+14...
//  3. req[2]=GETX, only snoop_share[2]=1 -> shared=0 (source excluded).
//  4. rr_ptr=1, req[0]=GETS and req[3]=PUTX together:
//     - macro defined: cache 3 wins.
//     - macro not defined: cache 3 wins (first set at or after ptr=1).
//     - rr_ptr=0, same reqs: cache 0 wins without the macro, cache 3 with it.
//  5. reset asserted during SNOOP -> next cycle IDLE, gnt=0, done never pulses, next grant starts from cache 0.
//  6. req[1] dropped during SNOOP -> done[1] still at T+4; req[2] raised during SNOOP is granted in the IDLE after DONE.

Source files
------------

// File: rtl/cacheLinePackage.sv
// rtl/cacheLinePackage.sv - shared cache-line bus types
// Purpose: bus operation and snoop-bus arbiter state encodings shared by
//          the cache controllers, the snoopers and the bus arbiter.
// Ports:   none (package).
package cacheLinePackage;

  typedef enum logic [2:0] {
    BUS_NONE,
    BUS_GETS,
    BUS_GETX,
    BUS_INV,
    BUS_PUTX
  } BusOp;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BCAST,
    ARB_SNOOP,
    ARB_DONE
  } ArbState;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin first-set picker
// Purpose: picks the first set bit of reqVec at or after ptr, wrapping
//          modulo N. Purely combinational.
// Ports:
//   reqVec    in  N        candidate requests
//   ptr       in  log2(N)  search start position
//   winOneHot out N        one-hot winner (0 when no request)
//   winIdx    out log2(N)  winner index (don't-care when anyReq=0)
//   anyReq    out 1        at least one request set
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]          reqVec,
  input  logic [$clog2(N)-1:0]  ptr,
  output logic [N-1:0]          winOneHot,
  output logic [$clog2(N)-1:0]  winIdx,
  output logic                  anyReq
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;
  logic           found;

  // Rotate so that bit 0 is the ptr position, find the lowest set bit,
  // then map the offset back to an absolute index.
  always_comb begin
    doubled = {reqVec, reqVec} >> ptr;
    rotated = doubled[N-1:0];
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = IW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    winIdx    = sum[IW-1:0];
    winOneHot = found ? (N'(1) << winIdx) : '0;
    anyReq    = found;
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin snooping MESI bus arbiter
// Purpose: grants the shared snoop bus to one cache at a time, broadcasts
//          op/addr/source, collects the share line from the other caches
//          over a fixed snoop window and returns done + shared to the owner.
// Build option: ARB_PUTX_PRIORITY_EN - PUTX requests win over all others,
//          round-robin within each class.
// Ports:
//   clk          in   1                   clock
//   reset        in   1                   synchronous, active-high
//   req          in   NUM_CACHES          per-cache request
//   req_op       in   NUM_CACHES x BusOp  requested op
//   req_addr     in   NUM_CACHES x ADDR_W requested line address
//   snoop_share  in   NUM_CACHES          cache holds the line valid
//   gnt          out  NUM_CACHES          one-hot grant, BCAST..DONE
//   bus_valid    out  1                   one-cycle broadcast strobe
//   bus_op       out  BusOp               op on bus, BUS_NONE when idle
//   bus_addr     out  ADDR_W              address on bus
//   bus_src      out  log2(NUM_CACHES)    owning cache index
//   done         out  NUM_CACHES          one-cycle completion to owner
//   shared       out  1                   valid with done
module snoop_bus_arbiter
  import cacheLinePackage::*;
#(
  parameter int NUM_CACHES   = 4,
  parameter int ADDR_W       = 32,
  parameter int SNOOP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CACHES-1:0]         req,
  input  BusOp                          req_op [NUM_CACHES],
  input  logic [ADDR_W-1:0]             req_addr [NUM_CACHES],
  input  logic [NUM_CACHES-1:0]         snoop_share,
  output logic [NUM_CACHES-1:0]         gnt,
  output logic                          bus_valid,
  output BusOp                          bus_op,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [$clog2(NUM_CACHES)-1:0] bus_src,
  output logic [NUM_CACHES-1:0]         done,
  output logic                          shared
);

  localparam int IW = $clog2(NUM_CACHES);
  localparam int CW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;

  ArbState               state;
  logic [IW-1:0]         rrPtr;
  logic [CW-1:0]         snoopCnt;
  logic                  shareAcc;
  logic                  shareHit;
  logic [NUM_CACHES-1:0] winOneHot;
  logic [IW-1:0]         winIdx;
  logic                  anyWin;

`ifdef ARB_PUTX_PRIORITY_EN
  logic [NUM_CACHES-1:0] putxReq;
  logic [NUM_CACHES-1:0] putxOneHot;
  logic [IW-1:0]         putxIdx;
  logic                  putxAny;
  logic [NUM_CACHES-1:0] allOneHot;
  logic [IW-1:0]         allIdx;
  logic                  allAny;

  always_comb begin
    putxReq = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      putxReq[i] = req[i] && (req_op[i] == BUS_PUTX);
    end
  end

  rr_priority_picker #(.N(NUM_CACHES)) putxPicker (
    .reqVec    (putxReq),
    .ptr       (rrPtr),
    .winOneHot (putxOneHot),
    .winIdx    (putxIdx),
    .anyReq    (putxAny)
  );

  rr_priority_picker #(.N(NUM_CACHES)) allPicker (
    .reqVec    (req),
    .ptr       (rrPtr),
    .winOneHot (allOneHot),
    .winIdx    (allIdx),
    .anyReq    (allAny)
  );

  // Any PUTX pending shadows the ordinary round-robin result.
  assign winOneHot = putxAny ? putxOneHot : allOneHot;
  assign winIdx    = putxAny ? putxIdx    : allIdx;
  assign anyWin    = allAny;
`else
  rr_priority_picker #(.N(NUM_CACHES)) allPicker (
    .reqVec    (req),
    .ptr       (rrPtr),
    .winOneHot (winOneHot),
    .winIdx    (winIdx),
    .anyReq    (anyWin)
  );
`endif

  // gnt is exactly onehot(src) while busy, so it doubles as the source mask.
  assign shareHit = |(snoop_share & ~gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rrPtr     <= '0;
      snoopCnt  <= '0;
      shareAcc  <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      shared    <= 1'b0;
      bus_valid <= 1'b0;
      bus_op    <= BUS_NONE;
      bus_addr  <= '0;
      bus_src   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (anyWin) begin
            gnt       <= winOneHot;
            bus_valid <= 1'b1;
            bus_op    <= req_op[winIdx];
            bus_addr  <= req_addr[winIdx];
            bus_src   <= winIdx;
            state     <= ARB_BCAST;
          end
        end
        ARB_BCAST: begin
          bus_valid <= 1'b0;
          shareAcc  <= 1'b0;
          snoopCnt  <= '0;
          state     <= ARB_SNOOP;
        end
        ARB_SNOOP: begin
          // Last window cycle folds its own sample straight into shared.
          if (snoopCnt == CW'(SNOOP_CYCLES - 1)) begin
            done   <= gnt;
            shared <= (shareAcc | shareHit) && (bus_op != BUS_PUTX);
            state  <= ARB_DONE;
          end else begin
            shareAcc <= shareAcc | shareHit;
            snoopCnt <= snoopCnt + CW'(1);
          end
        end
        ARB_DONE: begin
          rrPtr    <= (bus_src == IW'(NUM_CACHES - 1)) ? '0 : bus_src + IW'(1);
          done     <= '0;
          shared   <= 1'b0;
          gnt      <= '0;
          bus_op   <= BUS_NONE;
          bus_addr <= '0;
          bus_src  <= '0;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - self-checking bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;
  import cacheLinePackage::*;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] req;
  BusOp          opArr [NC];
  logic [AW-1:0] addrArr [NC];
  logic [NC-1:0] snoop_share;
  logic [NC-1:0] gnt;
  logic          bus_valid;
  BusOp          bus_op;
  logic [AW-1:0] bus_addr;
  logic [1:0]    bus_src;
  logic [NC-1:0] done;
  logic          shared;

  int nCompared = 0;
  int nMism = 0;
  logic [NC-1:0] shareSeq [32];

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.NUM_CACHES(NC), .ADDR_W(AW), .SNOOP_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_op      (opArr),
    .req_addr    (addrArr),
    .snoop_share (snoop_share),
    .gnt         (gnt),
    .bus_valid   (bus_valid),
    .bus_op      (bus_op),
    .bus_addr    (bus_addr),
    .bus_src     (bus_src),
    .done        (done),
    .shared      (shared)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMism++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [NC-1:0] reqMask;
    BusOp          ops [NC];
    logic [NC-1:0] share;
    int            prePtr;
    int            expWin;
    bit            expShared;
    logic [AW-1:0] addrBase;
  } vec_t;

  vec_t vecs [$];

  task automatic addRow(input logic [NC-1:0] m, input BusOp o0, input BusOp o1,
                        input BusOp o2, input BusOp o3, input logic [NC-1:0] sh,
                        input int pp, input int w, input bit es, input logic [AW-1:0] base);
    vec_t v;
    v.reqMask = m;
    v.ops[0] = o0; v.ops[1] = o1; v.ops[2] = o2; v.ops[3] = o3;
    v.share = sh; v.prePtr = pp; v.expWin = w; v.expShared = es; v.addrBase = base;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req = '0;
    snoop_share = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Called with the DUT idle; expected winner/shared come from the caller.
  task automatic transact(input string tag, input int expWin, input bit expShared);
    int validK = -1;
    int doneK = -1;
    int nValid = 0;
    logic [1:0]    srcSeen = '0;
    BusOp          opSeen = BUS_NONE;
    logic [AW-1:0] addrSeen = '0;
    logic [NC-1:0] gntSeen = '0;
    logic [NC-1:0] doneSeen = '0;
    logic          shSeen = 1'b0;
    snoop_share = shareSeq[0];
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 snoop_share = shareSeq[k];
      @(negedge clk);
      if (bus_valid) begin
        nValid++;
        if (validK < 0) begin
          validK = k; srcSeen = bus_src; opSeen = bus_op; addrSeen = bus_addr; gntSeen = gnt;
        end
      end
      if (done != '0) begin
        doneK = k; doneSeen = done; shSeen = shared;
        break;
      end
    end
    if (doneK < 0) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_validLat"}, 64'(validK), 64'd1);
      chk({tag, "_validCnt"}, 64'(nValid), 64'd1);
      chk({tag, "_src"}, 64'(srcSeen), 64'(expWin));
      chk({tag, "_op"}, 64'(opSeen), 64'(opArr[expWin]));
      chk({tag, "_addr"}, 64'(addrSeen), 64'(addrArr[expWin]));
      chk({tag, "_gnt"}, 64'(gntSeen), 64'(1 << expWin));
      chk({tag, "_doneLat"}, 64'(doneK), 64'(2 + SC));
      chk({tag, "_done"}, 64'(doneSeen), 64'(1 << expWin));
      chk({tag, "_shared"}, 64'(shSeen), 64'(expShared));
    end
    req = req & ~doneSeen;
    snoop_share = '0;
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: scan the eligible class starting at the pointer.
  function automatic int modelPick(logic [NC-1:0] pend, int ptr);
    logic [NC-1:0] cls;
`ifdef ARB_PUTX_PRIORITY_EN
    logic [NC-1:0] px;
`endif
    cls = pend;
`ifdef ARB_PUTX_PRIORITY_EN
    px = '0;
    for (int i = 0; i < NC; i++) px[i] = pend[i] && (opArr[i] == BUS_PUTX);
    if (px != '0) cls = px;
`endif
    for (int off = 0; off < NC; off++) begin
      if (cls[(ptr + off) % NC]) return (ptr + off) % NC;
    end
    return -1;
  endfunction

  function automatic bit modelShared(int w);
    logic [NC-1:0] seen = '0;
    for (int k = 2; k <= 1 + SC; k++) seen |= shareSeq[k];
    return (opArr[w] != BUS_PUTX) && ((seen & ~(NC'(1) << w)) != '0);
  endfunction

  initial begin
    int kDone [$];
    int iDone [$];
    int k1, kv2, k2;
    logic anyDone;
    logic [NC-1:0] pending;
    int ptrModel, w;

    for (int i = 0; i < NC; i++) begin
      opArr[i] = BUS_GETS;
      addrArr[i] = '0;
    end
    for (int k = 0; k < 32; k++) shareSeq[k] = '0;

    reset = 1'b1; req = '0; snoop_share = '0;
    @(posedge clk); @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_shared", 64'(shared), 64'd0);
    chk("rst_op", 64'(bus_op), 64'(BUS_NONE));
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_src", 64'(bus_src), 64'd0);

    addRow(4'b0010, BUS_GETS, BUS_GETS, BUS_GETS, BUS_GETS, 4'b1000, 0, 1, 1'b1, 32'h1040);
    addRow(4'b0100, BUS_GETS, BUS_GETS, BUS_GETX, BUS_GETS, 4'b0100, 0, 2, 1'b0, 32'h2000);
    addRow(4'b1001, BUS_GETS, BUS_GETS, BUS_GETS, BUS_PUTX, 4'b0000, 1, 3, 1'b0, 32'h3000);
`ifdef ARB_PUTX_PRIORITY_EN
    addRow(4'b1001, BUS_GETS, BUS_GETS, BUS_GETS, BUS_PUTX, 4'b0000, 0, 3, 1'b0, 32'h4000);
`else
    addRow(4'b1001, BUS_GETS, BUS_GETS, BUS_GETS, BUS_PUTX, 4'b0000, 0, 0, 1'b0, 32'h4000);
`endif
    addRow(4'b0001, BUS_PUTX, BUS_GETS, BUS_GETS, BUS_GETS, 4'b1110, 0, 0, 1'b0, 32'h5000);
    addRow(4'b0011, BUS_GETS, BUS_INV,  BUS_GETS, BUS_GETS, 4'b0100, 2, 0, 1'b1, 32'h6000);
    addRow(4'b1000, BUS_GETS, BUS_GETS, BUS_GETS, BUS_INV,  4'b0001, 3, 3, 1'b1, 32'h7000);

    foreach (vecs[r]) begin
      doReset();
      for (int i = 0; i < NC; i++) begin
        opArr[i] = BUS_GETS;
        addrArr[i] = vecs[r].addrBase ^ (AW'(i) << 12);
      end
      for (int k = 0; k < 32; k++) shareSeq[k] = '0;
      if (vecs[r].prePtr > 0) begin
        req = NC'(1) << (vecs[r].prePtr - 1);
        transact($sformatf("row%0d_pre", r), vecs[r].prePtr - 1, 1'b0);
      end
      for (int i = 0; i < NC; i++) opArr[i] = vecs[r].ops[i];
      for (int k = 0; k < 32; k++) shareSeq[k] = vecs[r].share;
      req = vecs[r].reqMask;
      transact($sformatf("row%0d", r), vecs[r].expWin, vecs[r].expShared);
    end

    // All four requesting continuously: rotation with a 3+SC cycle period.
    doReset();
    for (int i = 0; i < NC; i++) opArr[i] = BUS_GETS;
    req = 4'b1111;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < NC; i++) if (done[i]) begin kDone.push_back(k); iDone.push_back(i); end
    end
    req = '0;
    chk("rr_count", 64'(kDone.size()), 64'd5);
    for (int n = 0; n < kDone.size() && n < 5; n++) begin
      chk($sformatf("rr_cycle%0d", n), 64'(kDone[n]), 64'(2 + SC + n * (3 + SC)));
      chk($sformatf("rr_idx%0d", n), 64'(iDone[n]), 64'(n % NC));
    end

    // Reset during SNOOP abandons the transaction and the pointer.
    doReset();
    for (int k = 0; k < 32; k++) shareSeq[k] = '0;
    req = 4'b0100;
    transact("rst_pre", 2, 1'b0);
    req = 4'b0010;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1; req = '0;
    @(posedge clk); @(negedge clk);
    chk("rstmid_gnt", 64'(gnt), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    chk("rstmid_valid", 64'(bus_valid), 64'd0);
    chk("rstmid_op", 64'(bus_op), 64'(BUS_NONE));
    @(posedge clk);
    #1 reset = 1'b0;
    anyDone = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (done != '0) anyDone = 1'b1;
    end
    chk("rstmid_nodone", 64'(anyDone), 64'd0);
    req = 4'b1001;
    transact("rstmid_next", 0, 1'b0);

    // Owner drops req mid-window; a newcomer waits for the next IDLE.
    doReset();
    for (int i = 0; i < NC; i++) begin
      opArr[i] = BUS_GETS;
      addrArr[i] = 32'h100 * AW'(i);
    end
    req = 4'b0010;
    k1 = -1; kv2 = -1; k2 = -1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      if (k == 2) begin
        #1 req = 4'b0100; opArr[2] = BUS_GETX;
      end
      @(negedge clk);
      if (done[1] && k1 < 0) k1 = k;
      if (bus_valid && bus_src == 2'd2 && kv2 < 0) kv2 = k;
      if (done[2] && k2 < 0) begin k2 = k; req = '0; end
    end
    chk("drop_done1", 64'(k1), 64'(2 + SC));
    chk("drop_valid2", 64'(kv2), 64'(4 + SC));
    chk("drop_done2", 64'(k2), 64'(5 + 2 * SC));

    // Random traffic against the transaction-level model.
    doReset();
    pending = '0;
    ptrModel = 0;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NC; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1'b1;
          opArr[i] = BusOp'($urandom_range(1, 4));
          addrArr[i] = $urandom;
        end
      end
      if (pending == '0) begin
        pending[0] = 1'b1;
        opArr[0] = BUS_GETX;
        addrArr[0] = $urandom;
      end
      for (int k = 0; k < 32; k++) shareSeq[k] = NC'($urandom_range(0, 15));
      w = modelPick(pending, ptrModel);
      req = pending;
      transact($sformatf("rnd%0d", it), w, modelShared(w));
      pending[w] = 1'b0;
      ptrModel = (w + 1) % NC;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMism);
    $finish;
  end

endmodule
